// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: key legend, code width
// helper and the event record carried to the game logic.
package keypad_pkg;

  // Widest key code any legal geometry can need (8x8 keys -> 6 bits).
  localparam int CODE_MAX_W = 6;

  // Legend for a 4x4 pad, row-major, nibble i = code of key i:
  //   1 2 3 A / 4 5 6 B / 7 8 9 C / E(*) 0 F(#) D
  localparam logic [63:0] HEX_LEGEND = 64'hDF0E_C987_B654_A321;

  // Press/release event as seen by the consumer (code zero-extended).
  typedef struct packed {
    logic                  pressed;
    logic [CODE_MAX_W-1:0] code;
  } key_event_t;

  // Code width: enough for row*COLS+col, never narrower than a hex digit.
  function automatic int code_w(input int rows, input int cols);
    int w;
    w = $clog2(rows * cols);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_fifo.sv
// Small first-word-fall-through FIFO. The head word is presented while the
// FIFO is non-empty; a write into a full FIFO is accepted only when a read
// frees a slot in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks an active-low row strobe, samples the
// synchronised column lines once per row slot, debounces each key on its
// own, and queues press/release events for the consumer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 512,
  parameter int DEBOUNCE = 4,
  parameter int FIFO_D   = 4,
  parameter int MAP_HEX  = 1,
  localparam int CODE_W  = code_w(ROWS, COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COLS-1:0]      cols,
  output logic [ROWS-1:0]      rows,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic                 ev_pressed,
  output logic [CODE_W-1:0]    ev_code,
  output logic                 overflow,
  input  logic                 overflow_clr
);

  localparam int NKEYS = ROWS * COLS;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int KEY_W = $clog2(NKEYS);
  localparam int EV_W  = 1 + CODE_W;

  logic [CNT_W-1:0] scan_cnt;
  logic [ROW_W-1:0] row_sel;
  logic [ROW_W-1:0] row_nxt;
  logic             scan_end;
  logic [COLS-1:0]  sync1;
  logic [COLS-1:0]  sync2;
  logic [COLS-1:0]  sample;
  logic [3:0]       db_cnt [NKEYS];
  logic [COLS-1:0]  pending;
  logic [COLS-1:0]  iss_onehot;
  logic             iss_valid;
  logic [COL_W-1:0] iss_col;
  logic [ROW_W-1:0] ev_row;
  logic [KEY_W-1:0] key_idx;
  logic             new_pressed;
  logic [CODE_W-1:0] new_code;
  logic [EV_W-1:0]  head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             drop;

  assign scan_end   = (scan_cnt == CNT_W'(SCAN_DIV - 1));
  assign sample     = ~sync2;
  assign iss_valid  = |pending;
  assign iss_onehot = pending & (~pending + COLS'(1));

  // Next row: advance on the last cycle of the slot, wrapping after the last row.
  always_comb begin
    row_nxt = row_sel;
    if (scan_end) row_nxt = (row_sel == ROW_W'(ROWS - 1)) ? '0 : row_sel + ROW_W'(1);
  end

  // Scan timing and row strobe; the strobe follows the row selection on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      row_sel  <= '0;
      rows     <= '1;
    end else begin
      scan_cnt <= scan_end ? '0 : scan_cnt + CNT_W'(1);
      row_sel  <= row_nxt;
      rows     <= ~(ROWS'(1) << row_nxt);
    end
  end

  // Two-stage synchroniser for the asynchronous column lines (idle = pulled high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= cols;
      sync2 <= sync1;
    end
  end

  // Per-key debounce at the end of each row slot; issued events retire one pending bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_state <= '0;
      pending   <= '0;
      ev_row    <= '0;
      for (int k = 0; k < NKEYS; k++) db_cnt[k] <= '0;
    end else if (scan_end) begin
      ev_row <= row_sel;
      for (int k = 0; k < NKEYS; k++) begin
        if (k / COLS == int'(row_sel)) begin
          if (sample[k % COLS] == key_state[k]) begin
            db_cnt[k] <= '0;
          end else if (db_cnt[k] == 4'(DEBOUNCE - 1)) begin
            key_state[k]       <= ~key_state[k];
            db_cnt[k]          <= '0;
            pending[k % COLS]  <= 1'b1;
          end else begin
            db_cnt[k] <= db_cnt[k] + 4'd1;
          end
        end
      end
    end else begin
      pending <= pending & ~iss_onehot;
    end
  end

  // Serialiser: lowest pending column of the row just sampled forms the next event.
  always_comb begin
    iss_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (pending[c]) iss_col = COL_W'(c);
    end
    key_idx     = KEY_W'(int'(ev_row) * COLS + int'(iss_col));
    new_pressed = key_state[key_idx];
    if (MAP_HEX != 0) new_code = CODE_W'(HEX_LEGEND[4 * int'(key_idx) +: 4]);
    else              new_code = CODE_W'(key_idx);
  end

  sync_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (iss_valid),
    .wr_data ({new_pressed, new_code}),
    .rd_en   (ev_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ev_valid = ~fifo_empty;
  assign pop      = ev_valid & ev_ready;
  assign drop     = iss_valid & fifo_full & ~pop;
  assign {ev_pressed, ev_code} = ev_valid ? head : '0;

  // Sticky overflow flag; a drop in the same cycle wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner (4x4, SCAN_DIV=8, DEBOUNCE=3, FIFO depth 4, hex legend).
// A physical keypad model pulls column lines low for held keys on the strobed
// row. Key changes are applied at frame boundaries, and a frame-level reference
// model predicts key state, events and overflow; a monitor pops predicted events
// whenever the DUT hands one over.
module tb_keypad_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 8;
  localparam int DEBOUNCE = 3;
  localparam int FIFO_D   = 4;
  localparam int FRAME    = ROWS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [15:0] key_state;
  logic        ev_valid;
  logic        ev_ready = 1'b1;
  logic        ev_pressed;
  logic [3:0]  ev_code;
  logic        overflow;
  logic        overflow_clr = 1'b0;

  logic [15:0] held = '0;
  int          checks = 0;
  int          errors = 0;
  int          t_edge = 0;

  logic [4:0]  exp_q [$];
  logic [15:0] m_state = '0;
  int          m_cnt [16];
  logic        m_ovf = 1'b0;
  int          hex_tbl [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  keypad_scanner #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE),
    .FIFO_D   (FIFO_D),
    .MAP_HEX  (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cols         (cols),
    .rows         (rows),
    .key_state    (key_state),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_pressed   (ev_pressed),
    .ev_code      (ev_code),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  // Physical keypad: a held key connects its column to the row being driven low.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!rows[r] && held[r*COLS + c]) cols[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = '0;
    m_ovf   = 1'b0;
    for (int k = 0; k < 16; k++) m_cnt[k] = 0;
    exp_q.delete();
  endtask

  task automatic expect_event(input logic pressed, input int key);
    if (!ev_ready && exp_q.size() >= FIFO_D) m_ovf = 1'b1;
    else exp_q.push_back({pressed, 4'(hex_tbl[key])});
  endtask

  // One scan frame with the given keys held; ev_ready stays constant for the frame.
  task automatic frame(input logic [15:0] h, input bit clr);
    logic [3:0] er;
    held = h;
    overflow_clr = clr;
    if (clr) m_ovf = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (h[k] != m_state[k]) begin
        m_cnt[k]++;
        if (m_cnt[k] == DEBOUNCE) begin
          m_state[k] = h[k];
          m_cnt[k]   = 0;
          expect_event(h[k], k);
        end
      end else begin
        m_cnt[k] = 0;
      end
    end
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk);
      #1;
      overflow_clr = 1'b0;
      t_edge++;
      er = ~(4'b0001 << ((t_edge / SCAN_DIV) % ROWS));
      chk("rows_strobe", 32'(rows), 32'(er));
      if (i == 0 && clr) chk("overflow_after_clr", 32'(overflow), 32'(1'b0));
    end
    chk("key_state", 32'(key_state), 32'(m_state));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Scoreboard monitor: every accepted event must match the oldest prediction.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event_unexpected: got pressed=%0b code=%0h expected none (t=%0t)",
                 ev_pressed, ev_code, $time);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({ev_pressed, ev_code} !== e) begin
          errors++;
          $display("FAIL event: got pressed=%0b code=%0h expected pressed=%0b code=%0h (t=%0t)",
                   ev_pressed, ev_code, e[4], e[3:0], $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rh;
    for (int k = 0; k < 16; k++) m_cnt[k] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rows", 32'(rows), 32'hF);
    chk("rst_ev_valid", 32'(ev_valid), 32'h0);
    chk("rst_key_state", 32'(key_state), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_ev_pressed", 32'(ev_pressed), 32'h0);
    chk("rst_ev_code", 32'(ev_code), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    t_edge = 0;

    // Idle: four frames, no keys
    ev_ready = 1'b1;
    repeat (4) frame(16'h0000, 1'b0);
    chk("idle_ev_valid", 32'(ev_valid), 32'h0);

    // Hold row3/col1 (legend 0), then release
    repeat (4) frame(16'h1 << 13, 1'b0);
    repeat (3) frame(16'h0000, 1'b0);

    // Bounce on row1/col2 shorter than the debounce count
    repeat (2) frame(16'h1 << 6, 1'b0);
    repeat (2) frame(16'h0000, 1'b0);

    // Two keys on row 0 together: codes 1 then A
    repeat (3) frame(16'h0009, 1'b0);
    repeat (3) frame(16'h0000, 1'b0);

    // Consumer stalled, five presses: four buffered, fifth dropped
    ev_ready = 1'b0;
    repeat (3) frame(16'h0067, 1'b0);
    chk("ovf_set", 32'(overflow), 32'h1);
    ev_ready = 1'b1;
    frame(16'h0067, 1'b1);
    repeat (3) frame(16'h0000, 1'b0);

    // Reset mid-frame with two events queued
    ev_ready = 1'b0;
    repeat (3) frame(16'h0003, 1'b0);
    chk("queued_ev_valid", 32'(ev_valid), 32'h1);
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ev_valid", 32'(ev_valid), 32'h0);
    chk("midrst_key_state", 32'(key_state), 32'h0);
    chk("midrst_rows", 32'(rows), 32'hF);
    chk("midrst_overflow", 32'(overflow), 32'h0);
    held = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_rows", 32'(rows), 32'hF);
    @(negedge clk);
    ev_ready = 1'b1;
    rst = 1'b0;
    t_edge = 0;

    // Randomised key activity on rows 0..2 with random stalls and clears
    rh = '0;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 1) == 1) rh[$urandom_range(0, 11)] = ~rh[$urandom_range(0, 11)];
      if ($urandom_range(0, 2) == 0) rh = rh ^ (16'h1 << $urandom_range(0, 11));
      rh[15:12] = 4'h0;
      ev_ready = ($urandom_range(0, 3) != 0);
      frame(rh, ($urandom_range(0, 7) == 0));
    end

    // Release everything and drain
    ev_ready = 1'b1;
    repeat (4) frame(16'h0000, 1'b1);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    chk("final_ev_valid", 32'(ev_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
